// File: rtl/fir_sample_loader.sv
// Pad-side loader for the FIR core: synchronises strobe/mode/data, steers bytes to a sample FIFO or the coefficient port.
// Optional build macro FIR_LDR_OVERWRITE_EN: a push into a full FIFO overwrites the oldest entry instead of dropping.
module fir_sample_loader #(
  parameter int DEPTH    = 4,
  parameter int NUM_TAPS = 8,
  parameter int DW       = 8,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int LW = $clog2(DEPTH + 1),
  localparam int IW = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ena,
  input  logic [DW-1:0] data_in,
  input  logic          strobe,
  input  logic          mode,
  output logic [DW-1:0] sample_data,
  output logic          sample_valid,
  input  logic          sample_ready,
  output logic [DW-1:0] coeff_data,
  output logic [IW-1:0] coeff_idx,
  output logic          coeff_we,
  output logic          coeff_done,
  output logic [LW-1:0] fifo_level,
  output logic          overflow
);

  logic          r_strobe_s1, r_strobe_s2, r_strobe_s3;
  logic          r_mode_s1, r_mode_s2, r_mode_s3;
  logic [DW-1:0] r_data_s1, r_data_s2;

  logic [DW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [LW-1:0] r_level;
  logic          r_valid;
  logic [DW-1:0] r_head;
  logic          r_overflow;

  logic [IW-1:0] r_idx;
  logic [DW-1:0] r_coeff_data;
  logic [IW-1:0] r_coeff_idx;
  logic          r_coeff_we;
  logic          r_coeff_done;

  logic          w_edge, w_mode_chg, w_push, w_cwr, w_pop, w_full;
  logic          w_wr_en, w_rd_adv, w_ovf_set;
  logic [AW-1:0] w_rd_next;
  logic [LW-1:0] w_level_next;
  logic [DW-1:0] w_head_next;
  logic [IW-1:0] w_idx_base;
  logic          w_idx_last;

  // The chain runs regardless of ena; only the edge detector is gated.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_strobe_s1 <= 1'b0;
      r_strobe_s2 <= 1'b0;
      r_strobe_s3 <= 1'b0;
      r_mode_s1   <= 1'b0;
      r_mode_s2   <= 1'b0;
      r_mode_s3   <= 1'b0;
      r_data_s1   <= '0;
      r_data_s2   <= '0;
    end else begin
      r_strobe_s1 <= strobe;
      r_strobe_s2 <= r_strobe_s1;
      r_strobe_s3 <= r_strobe_s2;
      r_mode_s1   <= mode;
      r_mode_s2   <= r_mode_s1;
      r_mode_s3   <= r_mode_s2;
      r_data_s1   <= data_in;
      r_data_s2   <= r_data_s1;
    end
  end

  assign w_edge     = r_strobe_s2 & ~r_strobe_s3 & ena;
  assign w_mode_chg = r_mode_s2 ^ r_mode_s3;
  assign w_push     = w_edge & ~r_mode_s2;
  assign w_cwr      = w_edge & r_mode_s2;
  assign w_pop      = r_valid & sample_ready;
  assign w_full     = (r_level == LW'(DEPTH));

  always_comb begin
    w_wr_en   = 1'b0;
    w_rd_adv  = w_pop;
    w_ovf_set = 1'b0;
    if (w_push) begin
      if (!w_full || w_pop) begin
        w_wr_en = 1'b1;
      end else begin
        w_ovf_set = 1'b1;
`ifdef FIR_LDR_OVERWRITE_EN
        w_wr_en  = 1'b1;
        w_rd_adv = 1'b1;
`endif
      end
    end
  end

  assign w_level_next = r_level + LW'(w_wr_en) - LW'(w_rd_adv);
  assign w_rd_next    = r_rd_ptr + AW'(w_rd_adv);

  // Head is registered; bypass the incoming byte when it lands in the next head slot.
  always_comb begin
    w_head_next = r_mem[w_rd_next];
    if (w_wr_en && (r_wr_ptr == w_rd_next)) begin
      w_head_next = r_data_s2;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_valid    <= 1'b0;
      r_head     <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_wr_en) begin
        r_mem[r_wr_ptr] <= r_data_s2;
        r_wr_ptr        <= r_wr_ptr + AW'(1);
      end
      r_rd_ptr <= w_rd_next;
      r_level  <= w_level_next;
      r_valid  <= (w_level_next != '0);
      r_head   <= w_head_next;
      if (w_ovf_set) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // A mode change in the same cycle as an edge restarts the tap index before the write.
  assign w_idx_base = w_mode_chg ? '0 : r_idx;
  assign w_idx_last = (w_idx_base == IW'(NUM_TAPS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx        <= '0;
      r_coeff_data <= '0;
      r_coeff_idx  <= '0;
      r_coeff_we   <= 1'b0;
      r_coeff_done <= 1'b0;
    end else begin
      r_coeff_we <= w_cwr;
      if (w_cwr) begin
        r_coeff_data <= r_data_s2;
        r_coeff_idx  <= w_idx_base;
        r_idx        <= w_idx_last ? '0 : w_idx_base + IW'(1);
      end else if (w_mode_chg) begin
        r_idx <= '0;
      end
      if (w_cwr && w_idx_last) begin
        r_coeff_done <= 1'b1;
      end else if (w_mode_chg) begin
        r_coeff_done <= 1'b0;
      end
    end
  end

  assign sample_data  = r_head;
  assign sample_valid = r_valid;
  assign fifo_level   = r_level;
  assign overflow     = r_overflow;
  assign coeff_data   = r_coeff_data;
  assign coeff_idx    = r_coeff_idx;
  assign coeff_we     = r_coeff_we;
  assign coeff_done   = r_coeff_done;

endmodule

// File: tb/tb_fir_sample_loader.sv
// Self-checking bench for fir_sample_loader: vector tables plus scoreboard queues for FIFO pops and coefficient writes.
module tb_fir_sample_loader;
  localparam int DEPTH    = 4;
  localparam int NUM_TAPS = 8;
  localparam int DW       = 8;

  logic          clk = 1'b0;
  logic          rst_n, ena, strobe, mode, sample_ready;
  logic [DW-1:0] data_in;
  logic [DW-1:0] sample_data, coeff_data;
  logic          sample_valid, coeff_we, coeff_done, overflow;
  logic [2:0]    coeff_idx;
  logic [2:0]    fifo_level;

  fir_sample_loader #(.DEPTH(DEPTH), .NUM_TAPS(NUM_TAPS), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .data_in(data_in), .strobe(strobe), .mode(mode),
    .sample_data(sample_data), .sample_valid(sample_valid), .sample_ready(sample_ready),
    .coeff_data(coeff_data), .coeff_idx(coeff_idx), .coeff_we(coeff_we),
    .coeff_done(coeff_done), .fifo_level(fifo_level), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [7:0]  sq[$];
  logic [10:0] cq[$];
  bit exp_ovf = 1'b0;

  typedef struct { logic [7:0] data; int exp_level; bit exp_ovf; } svec_t;
  typedef struct { logic [7:0] data; int exp_idx; bit exp_done; } cvec_t;
  svec_t sv[5];
  cvec_t cv[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: a pop happens at the next posedge when valid & ready hold here.
  initial forever begin
    @(negedge clk);
    #1;
    if (rst_n) begin
      if (sample_valid && sample_ready) begin
        if (sq.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_pop: got 0x%0h expected none", sample_data);
        end else chk("pop_data", {24'h0, sample_data}, {24'h0, sq.pop_front()});
      end
      if (coeff_we) begin
        if (cq.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_coeff_we: got idx %0d data 0x%0h expected none", coeff_idx, coeff_data);
        end else chk("coeff_write", {21'h0, coeff_idx, coeff_data}, {21'h0, cq.pop_front()});
      end
    end
  end

  task automatic model_push(input logic [7:0] d);
    if (sq.size() < DEPTH) sq.push_back(d);
    else begin
      exp_ovf = 1'b1;
`ifdef FIR_LDR_OVERWRITE_EN
      void'(sq.pop_front());
      sq.push_back(d);
`endif
    end
  endtask

  task automatic strobe_byte(input logic [7:0] d, input logic m);
    @(negedge clk); data_in = d; mode = m;
    @(negedge clk); strobe = 1'b1;
    repeat (2) @(negedge clk);
    strobe = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic drain();
    @(negedge clk); sample_ready = 1'b1;
    for (int i = 0; i < 40 && sq.size() != 0; i++) @(negedge clk);
    sample_ready = 1'b0;
    chk("drain_remaining", sq.size(), 0);
    @(negedge clk);
    chk("drain_level", {29'h0, fifo_level}, 0);
    chk("drain_valid", {31'h0, sample_valid}, 0);
  endtask

  task automatic toggle_mode();
    @(negedge clk); mode = 1'b0;
    repeat (4) @(negedge clk);
    mode = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_valid"}, {31'h0, sample_valid}, 0);
    chk({tag, "_level"}, {29'h0, fifo_level}, 0);
    chk({tag, "_sdata"}, {24'h0, sample_data}, 0);
    chk({tag, "_we"}, {31'h0, coeff_we}, 0);
    chk({tag, "_idx"}, {29'h0, coeff_idx}, 0);
    chk({tag, "_cdata"}, {24'h0, coeff_data}, 0);
    chk({tag, "_done"}, {31'h0, coeff_done}, 0);
    chk({tag, "_ovf"}, {31'h0, overflow}, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 5; i++) begin
      sv[i].data      = 8'(i + 1);
      sv[i].exp_level = (i < 4) ? i + 1 : 4;
      sv[i].exp_ovf   = (i == 4);
    end
    for (int i = 0; i < 9; i++) begin
      cv[i].data     = 8'(8'h10 + i);
      cv[i].exp_idx  = i % NUM_TAPS;
      cv[i].exp_done = (i >= NUM_TAPS - 1);
    end

    rst_n = 1'b0; ena = 1'b1; strobe = 1'b0; mode = 1'b0; sample_ready = 1'b0; data_in = '0;
    #12;
    check_reset_outputs("reset");
    @(negedge clk); rst_n = 1'b1;

    // Pin-to-valid latency: three edges after the strobe rise.
    @(negedge clk); data_in = 8'h5A; mode = 1'b0;
    @(negedge clk); strobe = 1'b1; model_push(8'h5A);
    @(posedge clk); #1; chk("lat_e0_valid", {31'h0, sample_valid}, 0);
    @(posedge clk); #1; chk("lat_e1_valid", {31'h0, sample_valid}, 0);
    @(posedge clk); #1; chk("lat_e2_valid", {31'h0, sample_valid}, 1);
    chk("lat_data", {24'h0, sample_data}, 32'h5A);
    chk("lat_level", {29'h0, fifo_level}, 1);
    chk("lat_ovf", {31'h0, overflow}, 0);
    @(negedge clk); strobe = 1'b0;
    repeat (2) @(negedge clk);
    drain();

    for (int i = 0; i < 5; i++) begin
      model_push(sv[i].data);
      strobe_byte(sv[i].data, 1'b0);
      chk("fill_level", {29'h0, fifo_level}, sv[i].exp_level);
      chk("fill_ovf", {31'h0, overflow}, {31'h0, sv[i].exp_ovf});
    end
    drain();

    for (int i = 0; i < 9; i++) begin
      cq.push_back({3'(cv[i].exp_idx), cv[i].data});
      strobe_byte(cv[i].data, 1'b1);
      chk("coeff_pulse_seen", cq.size(), 0);
      chk("coeff_done", {31'h0, coeff_done}, {31'h0, cv[i].exp_done});
      chk("coeff_fifo_level", {29'h0, fifo_level}, 0);
    end

    toggle_mode();
    chk("toggle_done_clr", {31'h0, coeff_done}, 0);
    for (int i = 0; i < 3; i++) begin
      cq.push_back({3'(i), 8'(8'h20 + i)});
      strobe_byte(8'(8'h20 + i), 1'b1);
    end
    toggle_mode();
    cq.push_back({3'd0, 8'hAA});
    strobe_byte(8'hAA, 1'b1);
    chk("toggle_idx", {29'h0, coeff_idx}, 0);
    chk("toggle_data", {24'h0, coeff_data}, 32'hAA);
    chk("toggle_done", {31'h0, coeff_done}, 0);
    chk("toggle_fifo_level", {29'h0, fifo_level}, 0);
    chk("toggle_pulses", cq.size(), 0);

    // Strobe while disabled, then enable with strobe already high: no capture.
    ena = 1'b0;
    strobe_byte(8'h33, 1'b0);
    chk("ena_low_level", {29'h0, fifo_level}, 0);
    @(negedge clk); strobe = 1'b1;
    repeat (4) @(negedge clk);
    ena = 1'b1;
    repeat (4) @(negedge clk);
    chk("ena_rise_level", {29'h0, fifo_level}, 0);
    strobe = 1'b0;
    repeat (3) @(negedge clk);
    model_push(8'h44);
    strobe_byte(8'h44, 1'b0);
    chk("ena_next_level", {29'h0, fifo_level}, 1);
    chk("ena_next_data", {24'h0, sample_data}, 32'h44);
    drain();

    // Asynchronous reset mid-operation.
    for (int i = 0; i < 3; i++) begin
      model_push(8'(8'h61 + i));
      strobe_byte(8'(8'h61 + i), 1'b0);
    end
    for (int i = 0; i < NUM_TAPS; i++) begin
      cq.push_back({3'(i), 8'(8'h40 + i)});
      strobe_byte(8'(8'h40 + i), 1'b1);
    end
    chk("pre_rst_level", {29'h0, fifo_level}, 3);
    chk("pre_rst_done", {31'h0, coeff_done}, 1);
    chk("pre_rst_ovf", {31'h0, overflow}, {31'h0, exp_ovf});
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    sq.delete(); cq.delete(); exp_ovf = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    model_push(8'h7E);
    strobe_byte(8'h7E, 1'b0);
    chk("post_rst_level", {29'h0, fifo_level}, 1);
    chk("post_rst_data", {24'h0, sample_data}, 32'h7E);
    chk("post_rst_ovf", {31'h0, overflow}, 0);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
